// File: rtl/ahb_pkg.sv
`default_nettype none
// ahb_pkg -- AHB-lite htrans/hburst encodings, arbiter FSM state and burst-length decode.
// Rev 1.0
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam int BEAT_W = 4;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Beats-1 of a fixed-length burst; zero marks SINGLE/INCR as non-burst.
  function automatic logic [BEAT_W-1:0] burst_beats_m1(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arb_pick.sv
`default_nettype none
// ahb_arb_pick -- combinational winner select: first requester after last_idx, wrapping; parks on 0.
// Rev 1.0
module ahb_arb_pick #(
  parameter int NUM_MST = 2,
  parameter int MW      = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [MW-1:0]      last_idx,
  output logic [NUM_MST-1:0] grant,
  output logic [MW-1:0]      idx
);

  int   cand;
  logic found;

  always_comb begin
    grant    = '0;
    grant[0] = 1'b1;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= NUM_MST; i++) begin
      cand = (int'(last_idx) + i) % NUM_MST;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = MW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_arbiter.sv
`default_nettype none
// ahb_lite_arbiter -- AHB-lite bus arbiter with burst/lock hold; AHB_ARB_ROUND_ROBIN_EN selects
// round-robin instead of fixed priority (master 0 highest).  Rev 1.0
module ahb_lite_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int MW      = $clog2(NUM_MST)
) (
  input  logic               hclk,
  input  logic               hrstn,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_data,
  output logic               hmastlock
);

  arb_state_t         state, state_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [NUM_MST-1:0] grant_nxt, pick_grant;
  logic [MW-1:0]      master_nxt, pick_idx, last_idx;
  logic               owner_req, others_req, lock_req, burst_start, rearb;

  assign owner_req   = hbusreq[hmaster];
  assign others_req  = |(hbusreq & ~hgrant);
  assign lock_req    = hlock[hmaster];
  assign burst_start = (htrans == HTRANS_NONSEQ) && (burst_beats_m1(hburst) != '0);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_ptr;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn)                  rr_ptr <= '0;
    else if (grant_nxt != hgrant) rr_ptr <= master_nxt;
  end

  assign last_idx = rr_ptr;
`else
  // Searching from "after the last master" always starts at master 0: fixed priority.
  assign last_idx = MW'(NUM_MST - 1);
`endif

  ahb_arb_pick #(.NUM_MST(NUM_MST), .MW(MW)) u_pick (
    .req      (hbusreq),
    .last_idx (last_idx),
    .grant    (pick_grant),
    .idx      (pick_idx)
  );

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    rearb        = 1'b0;
    if (hready) begin
      case (state)
        ST_ARB: begin
          if (lock_req) begin
            state_nxt = ST_LOCKED;
          end else if (burst_start) begin
            state_nxt    = ST_BURST;
            beat_cnt_nxt = burst_beats_m1(hburst);
          end else begin
            rearb = !owner_req || (others_req && (htrans == HTRANS_IDLE));
          end
        end
        ST_BURST: begin
          case (htrans)
            HTRANS_SEQ: begin
              beat_cnt_nxt = beat_cnt - 1'b1;
              if (beat_cnt_nxt == '0) state_nxt = ST_ARB;
            end
            HTRANS_NONSEQ: begin
              if (lock_req) begin
                state_nxt    = ST_LOCKED;
                beat_cnt_nxt = '0;
              end else if (burst_start) begin
                beat_cnt_nxt = burst_beats_m1(hburst);
              end else begin
                state_nxt    = ST_ARB;
                beat_cnt_nxt = '0;
              end
            end
            HTRANS_IDLE: begin
              state_nxt    = ST_ARB;
              beat_cnt_nxt = '0;
            end
            default: ;
          endcase
        end
        // The first completed phase with hlock low is the last locked phase.
        ST_LOCKED: if (!lock_req) state_nxt = ST_ARB;
        default:   state_nxt = ST_ARB;
      endcase
    end
  end

  always_comb begin
    grant_nxt  = hgrant;
    master_nxt = hmaster;
    if (rearb) begin
      grant_nxt  = pick_grant;
      master_nxt = pick_idx;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state        <= ST_ARB;
      beat_cnt     <= '0;
      hgrant       <= NUM_MST'(1);
      hmaster      <= '0;
      hmaster_data <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      hgrant   <= grant_nxt;
      hmaster  <= master_nxt;
      if (hready) hmaster_data <= hmaster;
    end
  end

  assign hmastlock = (state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_arbiter.sv
`default_nettype none
// tb_ahb_lite_arbiter -- directed vectors with a queue scoreboard checked by a negedge monitor.
// Rev 1.0
module tb_ahb_lite_arbiter;
  import ahb_pkg::*;

  localparam int NUM_MST = 2;
  localparam int MW      = 1;

  logic               hclk = 1'b0;
  logic               hrstn = 1'b0;
  logic [NUM_MST-1:0] hbusreq = '0;
  logic [NUM_MST-1:0] hlock = '0;
  logic [1:0]         htrans = HTRANS_IDLE;
  logic [2:0]         hburst = HBURST_SINGLE;
  logic               hready = 1'b1;
  logic [NUM_MST-1:0] hgrant;
  logic [MW-1:0]      hmaster;
  logic [MW-1:0]      hmaster_data;
  logic               hmastlock;

  always #5 hclk = ~hclk;

  ahb_lite_arbiter #(.NUM_MST(NUM_MST), .MW(MW)) dut (
    .hclk         (hclk),
    .hrstn        (hrstn),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  typedef struct {
    int                 due;
    logic [NUM_MST-1:0] grant;
    logic [MW-1:0]      master;
    logic [MW-1:0]      mdata;
    logic               lock;
    string              name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  always @(negedge hclk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.due != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", mon_e.name, mon_e.due, cyc);
      end else if ({hgrant, hmaster, hmaster_data, hmastlock} !==
                   {mon_e.grant, mon_e.master, mon_e.mdata, mon_e.lock}) begin
        failures++;
        $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b",
                 mon_e.name, hgrant, hmaster, hmaster_data, hmastlock,
                 mon_e.grant, mon_e.master, mon_e.mdata, mon_e.lock);
      end
    end
  end

  task automatic expect_at(input int due, input logic [1:0] eg, input logic em, input logic ed,
                           input logic el, input string name);
    exp_t e;
    e.due = due; e.grant = eg; e.master = em; e.mdata = ed; e.lock = el; e.name = name;
    exp_q.push_back(e);
  endtask

  // Apply one cycle of inputs; the expectation is for the outputs after the coming edge.
  task automatic step(input logic [1:0] req, input logic [1:0] lck, input logic [1:0] trans,
                      input logic [2:0] burst, input logic rdy,
                      input logic [1:0] eg, input logic em, input logic ed, input logic el,
                      input string name);
    hbusreq = req; hlock = lck; htrans = trans; hburst = burst; hready = rdy;
    expect_at(cyc + 1, eg, em, ed, el, name);
    @(posedge hclk); #1;
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    expect_at(cyc, 2'b01, 1'b0, 1'b0, 1'b0, "reset_hold");
    @(posedge hclk); #1;
    hrstn = 1'b1;

    // Park on master 0 with no requests.
    repeat (2) step(2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 0, "park");

    // INCR4 burst by M1 holds the grant even after M1 drops its request.
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "grant_m1");
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 2'b10, 1, 1, 0, "burst_beat1");
    repeat (3) step(2'b01, 2'b00, HTRANS_SEQ, HBURST_INCR4, 1'b1, 2'b10, 1, 1, 0, "burst_seq");
    step(2'b01, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "burst_release");

    // Wait states: no arbitration or burst entry with hready low, counter frozen mid-burst.
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "stall_grant_m1");
    step(2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR4,  1'b0, 2'b10, 1, 0, 0, "stall_mdata_hold");
    step(2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 2'b10, 1, 1, 0, "stall_beat1");
    step(2'b01, 2'b00, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 2'b10, 1, 1, 0, "stall_beat2");
    repeat (3) step(2'b01, 2'b00, HTRANS_SEQ, HBURST_INCR4, 1'b0, 2'b10, 1, 1, 0, "stall_wait");
    repeat (2) step(2'b01, 2'b00, HTRANS_SEQ, HBURST_INCR4, 1'b1, 2'b10, 1, 1, 0, "stall_tail");
    step(2'b01, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "stall_release");

    // Locked sequence by M0 with M1 requesting.
    step(2'b11, 2'b01, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 1, "lock_enter");
    repeat (2) step(2'b11, 2'b01, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 1, "lock_single");
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 0, "lock_last_phase");
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "lock_release");

    // Both masters request continuously; each does one SINGLE then goes idle.
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b10, 1, 1, 0, "fair_1");
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "fair_2");
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 0, "fair_3");
`ifdef AHB_ARB_ROUND_ROBIN_EN
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "fair_4");
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b10, 1, 1, 0, "fair_5");
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "fair_6");
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 0, "fair_7");
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "fair_8");
    step(2'b00, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "fair_park");
`else
    for (int i = 4; i <= 8; i++)
      step(2'b11, 2'b00, (i % 2 == 0) ? HTRANS_IDLE : HTRANS_NONSEQ, HBURST_SINGLE, 1'b1,
           2'b01, 0, 0, 0, "fixed_prio_hold");
    step(2'b00, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 0, 0, "fair_park");
`endif

    // INCR8 terminated by IDLE after beat 2.
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "early_grant_m1");
    step(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, 2'b10, 1, 1, 0, "early_beat1");
    step(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8,  1'b1, 2'b10, 1, 1, 0, "early_beat2");
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_INCR8,  1'b1, 2'b10, 1, 1, 0, "early_idle");
    step(2'b11, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b01, 0, 1, 0, "early_m0_granted");

    // Lock wins over a coinciding burst start.
    step(2'b01, 2'b01, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 2'b01, 0, 0, 1, "lock_over_burst");
    step(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 2'b01, 0, 0, 0, "lock_over_burst_exit");

    // Reset in the middle of a burst abandons it.
    step(2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1, 0, 0, "rst_grant_m1");
    step(2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, 2'b10, 1, 1, 0, "rst_burst_start");
    @(negedge hclk); #1;
    hrstn = 1'b0;
    expect_at(cyc + 1, 2'b01, 0, 0, 0, "rst_mid_burst");
    @(posedge hclk); #1;
    hrstn = 1'b1;
    step(2'b00, 2'b00, HTRANS_SEQ,    HBURST_INCR16, 1'b1, 2'b01, 0, 0, 0, "rst_no_resume");
    step(2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR16, 1'b1, 2'b10, 1, 0, 0, "rst_arb_again");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge hclk);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation for cycle %0d never sampled", mon_e.name, mon_e.due);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
